// File: rtl/dca_step_issuer_pkg.sv
// Shared types for the matrix step issuer: FSM encoding, instruction field positions, counter width.
// Field layout from bit 0: no_cal, load_acc, ld_sel[NUM_LOAD_CH], st_req, last; the remaining bits are opaque.
package dca_step_issuer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CAL   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int IDX_NO_CAL   = 0;
    localparam int IDX_LOAD_ACC = 1;
    localparam int IDX_LD_SEL   = 2;

    function automatic int idx_st_req(input int num_load_ch);
        return IDX_LD_SEL + num_load_ch;
    endfunction

    function automatic int idx_last(input int num_load_ch);
        return IDX_LD_SEL + num_load_ch + 1;
    endfunction

    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/dca_matrix_step_issuer_credit.sv
// Saturating up/down counter of outstanding result stores; simultaneous inc and dec cancel out.
// Registered count, full/empty decoded from the register; overflow and underflow are flagged in simulation.
module dca_credit_counter #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rstnn,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign full  = (count_q == W'(MAX));
    assign empty = (count_q == '0);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (inc && !dec && !full) begin
            count_d = count_q + W'(1);
        end else if (dec && !inc && !empty) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (!rstnn) !(dec && !inc && empty))
        else $error("credit counter: store completion with nothing outstanding");
    a_no_overflow: assert property (@(posedge clk) disable iff (!rstnn) !(inc && !dec && full))
        else $error("credit counter: store issued beyond the outstanding limit");

endmodule

// File: rtl/dca_matrix_step_issuer.sv
// Issues matrix step instructions to load/MAC/store units (IDLE/CAL/DRAIN); issue handshakes are same-cycle combinational.
// Stalls on any unready load channel, MAC, accumulator or store credit. Perf counters built only with DCA_STEP_ISSUER_PERF_EN.
module dca_matrix_step_issuer
    import dca_step_issuer_pkg::*;
#(
    parameter int NUM_LOAD_CH   = 2,
    parameter int MAX_STORE_OUT = 4,
    parameter int BW_INST       = 32
) (
    input  logic                   clk,
    input  logic                   rstnn,
    input  logic                   clear,
    input  logic                   enable,
    output logic                   busy,
    input  logic                   inst_valid,
    input  logic [BW_INST-1:0]     inst,
    output logic                   inst_ready,
    output logic [NUM_LOAD_CH-1:0] ld_req_valid,
    input  logic [NUM_LOAD_CH-1:0] ld_req_ready,
    input  logic                   mac_ready,
    output logic                   mac_start,
    output logic [BW_INST-1:0]     mac_inst,
    input  logic                   mac_done,
    output logic                   st_req_valid,
    input  logic                   st_done,
    input  logic                   acc_ready,
    output logic                   acc_load,
    output logic                   step_last,
    output logic [31:0]            perf_issue_cnt,
    output logic [31:0]            perf_stall_cnt
);

    localparam int CW      = cnt_width(MAX_STORE_OUT);
    localparam int IDX_ST  = idx_st_req(NUM_LOAD_CH);
    localparam int IDX_LST = idx_last(NUM_LOAD_CH);

    state_e                 state_q;
    logic                   st_req_q;
    logic                   last_q;
    logic [CW-1:0]          outstanding;
    logic                   cnt_full;
    logic                   cnt_empty;

    logic                   f_no_cal;
    logic                   f_load_acc;
    logic [NUM_LOAD_CH-1:0] f_ld_sel;
    logic                   f_st_req;
    logic                   f_last;
    logic                   is_idle;
    logic                   ld_ok;
    logic                   issue;
    logic                   consume;
    logic                   st_inc;
    logic                   drain_done;

    assign f_no_cal   = inst[IDX_NO_CAL];
    assign f_load_acc = inst[IDX_LOAD_ACC];
    assign f_ld_sel   = inst[IDX_LD_SEL +: NUM_LOAD_CH];
    assign f_st_req   = inst[IDX_ST];
    assign f_last     = inst[IDX_LST];

    assign is_idle    = (state_q == ST_IDLE);
    assign ld_ok      = &(ld_req_ready | ~f_ld_sel);
    assign issue      = is_idle & enable & inst_valid & ~f_no_cal & mac_ready & ld_ok
                      & (~f_st_req | ~cnt_full);
    assign consume    = is_idle & enable & inst_valid & f_no_cal & (~f_load_acc | acc_ready);
    assign st_inc     = (state_q == ST_CAL) & mac_done & st_req_q;
    assign drain_done = (state_q == ST_DRAIN) & (cnt_empty | ((outstanding == CW'(1)) & st_done));

    // Combinational outputs are gated by rstnn so every output is 0 while reset is held.
    assign busy         = ~is_idle;
    assign inst_ready   = rstnn & (issue | consume);
    assign mac_start    = rstnn & issue;
    assign ld_req_valid = {NUM_LOAD_CH{rstnn & issue}} & f_ld_sel;
    assign mac_inst     = rstnn ? inst : '0;
    assign st_req_valid = rstnn & st_inc;
    assign acc_load     = rstnn & consume & f_load_acc;
    assign step_last    = rstnn & drain_done;

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q  <= ST_IDLE;
            st_req_q <= 1'b0;
            last_q   <= 1'b0;
        end else if (clear) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        state_q  <= ST_CAL;
                        st_req_q <= f_st_req;
                        last_q   <= f_last;
                    end
                end
                ST_CAL: begin
                    if (mac_done) begin
                        state_q <= last_q ? ST_DRAIN : ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Outstanding stores survive clear so that in-flight stores still retire against it.
    dca_credit_counter #(
        .MAX (MAX_STORE_OUT),
        .W   (CW)
    ) u_store_credit (
        .clk   (clk),
        .rstnn (rstnn),
        .inc   (st_inc),
        .dec   (st_done),
        .count (outstanding),
        .full  (cnt_full),
        .empty (cnt_empty)
    );

`ifdef DCA_STEP_ISSUER_PERF_EN
    logic [31:0] perf_issue_q;
    logic [31:0] perf_stall_q;
    logic        stall;

    assign stall = is_idle & inst_valid & enable & ~issue & ~consume;

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else if (clear) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (issue) perf_issue_q <= perf_issue_q + 32'd1;
            if (stall) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_issue_cnt = perf_issue_q;
    assign perf_stall_cnt = perf_stall_q;
`else
    assign perf_issue_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dca_matrix_step_issuer.sv
// Random plus directed stimulus for dca_matrix_step_issuer, checked by a rule-level model and an instruction scoreboard.
module tb_dca_matrix_step_issuer;

    localparam int MAX = 4;

    logic        clk;
    logic        rstnn;
    logic        clear;
    logic        enable;
    logic        busy;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_ready;
    logic [1:0]  ld_req_valid;
    logic [1:0]  ld_req_ready;
    logic        mac_ready;
    logic        mac_start;
    logic [31:0] mac_inst;
    logic        mac_done;
    logic        st_req_valid;
    logic        st_done;
    logic        acc_ready;
    logic        acc_load;
    logic        step_last;
    logic [31:0] perf_issue_cnt;
    logic [31:0] perf_stall_cnt;

    dca_matrix_step_issuer #(
        .NUM_LOAD_CH   (2),
        .MAX_STORE_OUT (MAX),
        .BW_INST       (32)
    ) dut (
        .clk            (clk),
        .rstnn          (rstnn),
        .clear          (clear),
        .enable         (enable),
        .busy           (busy),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_ready     (inst_ready),
        .ld_req_valid   (ld_req_valid),
        .ld_req_ready   (ld_req_ready),
        .mac_ready      (mac_ready),
        .mac_start      (mac_start),
        .mac_inst       (mac_inst),
        .mac_done       (mac_done),
        .st_req_valid   (st_req_valid),
        .st_done        (st_done),
        .acc_ready      (acc_ready),
        .acc_load       (acc_load),
        .step_last      (step_last),
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    // Reference state: one step in MAC, a last step waiting for stores, stores in flight.
    logic        m_inflight = 1'b0;
    logic        m_drain    = 1'b0;
    logic        m_st       = 1'b0;
    logic        m_last     = 1'b0;
    int          pending    = 0;
    logic [31:0] m_pi       = '0;
    logic [31:0] m_ps       = '0;
    logic        acc_seen   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic nc, input logic la, input logic [1:0] ld,
                                       input logic st, input logic lst);
        logic [31:0] r;
        r      = $urandom;
        r[0]   = nc;
        r[1]   = la;
        r[3:2] = ld;
        r[4]   = st;
        r[5]   = lst;
        return r;
    endfunction

    task automatic present(input logic [31:0] i);
        exp_q.push_back(i);
        inst       = i;
        inst_valid = 1'b1;
    endtask

    task automatic wait_accept();
        int k;
        for (k = 0; k < 100; k++) begin
            tick();
            if (acc_seen) break;
        end
        if (k == 100) chk("accept_timeout", 32'd0, 32'd1);
        inst_valid = 1'b0;
    endtask

    task automatic do_step(input logic [31:0] i);
        present(i);
        wait_accept();
        if (!i[0]) begin
            mac_done = 1'b1;
            tick();
            mac_done = 1'b0;
        end
    endtask

    task automatic quiesce();
        int k;
        for (k = 0; k < 500; k++) begin
            tick();
            if (inst_valid && acc_seen) inst_valid = 1'b0;
            enable       = 1'b1;
            mac_ready    = 1'b1;
            ld_req_ready = 2'b11;
            acc_ready    = 1'b1;
            mac_done     = m_inflight;
            st_done      = (pending > 0);
            if (!inst_valid && !m_inflight && !m_drain && pending == 0) break;
        end
        if (k == 500) chk("quiesce_timeout", 32'd0, 32'd1);
        mac_done = 1'b0;
        st_done  = 1'b0;
    endtask

    task automatic drive_random();
        enable       = ($urandom_range(0, 7) != 0);
        ld_req_ready = 2'($urandom_range(0, 3));
        mac_ready    = ($urandom_range(0, 3) != 0);
        acc_ready    = 1'($urandom_range(0, 1));
        mac_done     = m_inflight && ($urandom_range(0, 2) == 0);
        st_done      = (pending > 0) && ($urandom_range(0, 3) == 0);
        if (inst_valid && acc_seen) inst_valid = 1'b0;
        if (!inst_valid && $urandom_range(0, 1) == 1) present($urandom);
    endtask

    // Monitor: derives every handshake output from the issue rules and pops the scoreboard on acceptance.
    always @(negedge clk) begin : mon
        logic       idle, ld_ok, e_issue, e_cons, e_stv, e_last, e_stall;
        logic [1:0] f_ld;
        logic [31:0] popped;
        if (!rstnn) begin
            chk("rst_outs", {24'd0, busy, inst_ready, mac_start, ld_req_valid, st_req_valid, acc_load, step_last}, 32'd0);
            chk("rst_mac_inst", mac_inst, 32'd0);
            chk("rst_perf", perf_issue_cnt | perf_stall_cnt, 32'd0);
            m_inflight = 1'b0;
            m_drain    = 1'b0;
            pending    = 0;
            m_pi       = '0;
            m_ps       = '0;
            acc_seen   = 1'b0;
            exp_q.delete();
        end else begin
            f_ld    = inst[3:2];
            idle    = !m_inflight && !m_drain;
            ld_ok   = ((f_ld & ~ld_req_ready) == 2'b00);
            e_issue = idle && enable && inst_valid && !inst[0] && mac_ready && ld_ok
                      && (!inst[4] || pending < MAX);
            e_cons  = idle && enable && inst_valid && inst[0] && (!inst[1] || acc_ready);
            e_stall = idle && enable && inst_valid && !e_issue && !e_cons;
            e_stv   = m_inflight && mac_done && m_st;
            e_last  = m_drain && (pending == 0 || (pending == 1 && st_done));

            chk("busy", busy, !idle);
            chk("inst_ready", inst_ready, e_issue || e_cons);
            chk("mac_start", mac_start, e_issue);
            chk("ld_req_valid", ld_req_valid, e_issue ? f_ld : 2'b00);
            chk("acc_load", acc_load, e_cons && inst[1]);
            chk("st_req_valid", st_req_valid, e_stv);
            chk("step_last", step_last, e_last);
            chk("mac_inst", mac_inst, inst);
`ifdef DCA_STEP_ISSUER_PERF_EN
            chk("perf_issue", perf_issue_cnt, m_pi);
            chk("perf_stall", perf_stall_cnt, m_ps);
`else
            chk("perf_tied", perf_issue_cnt | perf_stall_cnt, 32'd0);
`endif
            if (inst_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_accept", 32'd1, 32'd0);
                end else begin
                    popped = exp_q.pop_front();
                    chk("sb_accepted_inst", mac_inst, popped);
                end
            end
            acc_seen = inst_ready;

            if (clear) begin
                m_inflight = 1'b0;
                m_drain    = 1'b0;
                m_pi       = '0;
                m_ps       = '0;
            end else begin
                if (e_issue) begin
                    m_inflight = 1'b1;
                    m_st       = inst[4];
                    m_last     = inst[5];
                end else if (m_inflight && mac_done) begin
                    m_inflight = 1'b0;
                    m_drain    = m_last;
                end
                if (e_last) m_drain = 1'b0;
                if (e_issue) m_pi = m_pi + 32'd1;
                if (e_stall) m_ps = m_ps + 32'd1;
            end
            pending = pending + (e_stv ? 1 : 0) - (st_done ? 1 : 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstnn        = 1'b0;
        clear        = 1'b0;
        enable       = 1'b0;
        inst_valid   = 1'b0;
        inst         = '0;
        ld_req_ready = 2'b00;
        mac_ready    = 1'b0;
        mac_done     = 1'b0;
        st_done      = 1'b0;
        acc_ready    = 1'b0;
        repeat (3) tick();
        rstnn = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            tick();
            drive_random();
        end
        quiesce();

        // Single step: issue at 0, mac_done at 3, st_done at 6, idle at 7.
        present(mk(1'b0, 1'b0, 2'b11, 1'b1, 1'b1));
        @(negedge clk); chk("t32_issue", mac_start, 1'b1); chk("t32_ld", ld_req_valid, 2'b11);
        tick(); inst_valid = 1'b0;
        tick();
        tick(); mac_done = 1'b1;
        @(negedge clk); chk("t32_st_req", st_req_valid, 1'b1);
        tick(); mac_done = 1'b0;
        tick();
        tick(); st_done = 1'b1;
        @(negedge clk); chk("t32_step_last", step_last, 1'b1);
        tick(); st_done = 1'b0;
        @(negedge clk); chk("t32_idle", busy, 1'b0);
        quiesce();

        // Store credit limit: the fifth storing step waits for one completion.
        for (int s = 0; s < 4; s++) do_step(mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0));
        present(mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); chk("t33_hold", inst_ready, 1'b0);
            tick();
        end
        st_done = 1'b1;
        @(negedge clk); chk("t33_hold_done", inst_ready, 1'b0);
        tick(); st_done = 1'b0;
        @(negedge clk); chk("t33_issue", inst_ready, 1'b1);
        tick(); inst_valid = 1'b0; mac_done = 1'b1;
        tick(); mac_done = 1'b0;
        quiesce();

        // Per-channel load readiness.
        ld_req_ready = 2'b01;
        present(mk(1'b0, 1'b0, 2'b11, 1'b0, 1'b0));
        @(negedge clk); chk("t34_blocked", inst_ready, 1'b0);
        tick(); ld_req_ready = 2'b11;
        @(negedge clk); chk("t34_issue", inst_ready, 1'b1); chk("t34_ld11", ld_req_valid, 2'b11);
        tick(); inst_valid = 1'b0; mac_done = 1'b1;
        tick(); mac_done = 1'b0; ld_req_ready = 2'b01;
        present(mk(1'b0, 1'b0, 2'b01, 1'b0, 1'b0));
        @(negedge clk); chk("t34_issue01", inst_ready, 1'b1); chk("t34_ld01", ld_req_valid, 2'b01);
        tick(); inst_valid = 1'b0; mac_done = 1'b1;
        tick(); mac_done = 1'b0; ld_req_ready = 2'b11;
        quiesce();

        // Drain with two stores outstanding, then drain with none.
        do_step(mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0));
        do_step(mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b1));
        @(negedge clk); chk("t35_wait0", step_last, 1'b0);
        tick(); st_done = 1'b1;
        @(negedge clk); chk("t35_wait1", step_last, 1'b0);
        tick(); st_done = 1'b0;
        @(negedge clk); chk("t35_still_busy", busy, 1'b1);
        tick(); st_done = 1'b1;
        @(negedge clk); chk("t35_last", step_last, 1'b1);
        tick(); st_done = 1'b0;
        @(negedge clk); chk("t35_idle", busy, 1'b0);
        do_step(mk(1'b0, 1'b0, 2'b00, 1'b0, 1'b1));
        @(negedge clk); chk("t35_last_empty", step_last, 1'b1);
        tick();
        @(negedge clk); chk("t35_idle_empty", busy, 1'b0);
        quiesce();

        // Accumulator preload waits on acc_ready; stall count starts from a clear.
        clear = 1'b1;
        tick(); clear = 1'b0; acc_ready = 1'b0;
        present(mk(1'b1, 1'b1, 2'b00, 1'b0, 1'b0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); chk("t36_wait", inst_ready, 1'b0);
            tick();
        end
        acc_ready = 1'b1;
        @(negedge clk); chk("t36_acc_load", acc_load, 1'b1); chk("t36_ready", inst_ready, 1'b1);
        tick(); inst_valid = 1'b0;
        @(negedge clk); chk("t36_idle", busy, 1'b0);
`ifdef DCA_STEP_ISSUER_PERF_EN
        chk("t36_perf_stall", perf_stall_cnt, 32'd3);
`else
        chk("t36_perf_stall", perf_stall_cnt, 32'd0);
`endif
        quiesce();

        // Clear in CAL keeps the two outstanding stores.
        do_step(mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0));
        do_step(mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0));
        present(mk(1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
        wait_accept();
        clear = 1'b1;
        @(negedge clk); chk("t37_in_cal", busy, 1'b1);
        tick(); clear = 1'b0;
        @(negedge clk); chk("t37_cleared", busy, 1'b0);
        do_step(mk(1'b0, 1'b0, 2'b00, 1'b0, 1'b1));
        @(negedge clk); chk("t37_drain_held", step_last, 1'b0);
        tick(); st_done = 1'b1;
        @(negedge clk); chk("t37_drain_one", step_last, 1'b0);
        tick(); st_done = 1'b1;
        @(negedge clk); chk("t37_drain_last", step_last, 1'b1);
        tick(); st_done = 1'b0;
        quiesce();

        // Asynchronous reset in DRAIN with a store outstanding.
        do_step(mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b1));
        inst = mk(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        inst_valid = 1'b1;
        #2 rstnn = 1'b0;
        #1;
        chk("t37_rst_outs", {24'd0, busy, inst_ready, mac_start, ld_req_valid, st_req_valid, acc_load, step_last}, 32'd0);
        chk("t37_rst_mac_inst", mac_inst, 32'd0);
        tick(); inst_valid = 1'b0;
        tick(); rstnn = 1'b1;
        @(negedge clk); chk("t37_post_rst", busy, 1'b0);
        quiesce();
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dca_matrix_step_issuer.md
DCA_MATRIX_STEP_ISSUER -- requirements
Module: dca_matrix_step_issuer

Interface
REQ-001 SHALL have parameter NUM_LOAD_CH, default 2: number of operand-load LSU channels (1..8).
REQ-002 SHALL have parameter MAX_STORE_OUT, default 4: maximum outstanding result stores (1..16).
REQ-003 SHALL have parameter BW_INST, default 32: step instruction width.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port rstnn, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port clear, input, 1: synchronous FSM clear.
REQ-007 SHALL have port enable, input, 1: issue enable.
REQ-008 SHALL have port busy, output, 1: FSM not IDLE.
REQ-009 SHALL have ports inst_valid (input, 1), inst (input, BW_INST) and inst_ready (output, 1): step instruction handshake.
REQ-010 SHALL have ports ld_req_valid (output, NUM_LOAD_CH) and ld_req_ready (input, NUM_LOAD_CH): per-channel operand load request.
REQ-011 SHALL have ports mac_ready (input, 1), mac_start (output, 1), mac_inst (output, BW_INST) and mac_done (input, 1): MAC array handshake.
REQ-012 SHALL have ports st_req_valid (output, 1) and st_done (input, 1): store issue and store completion.
REQ-013 SHALL have ports acc_ready (input, 1) and acc_load (output, 1): accumulator preload.
REQ-014 SHALL have port step_last (output, 1): end-of-sequence pulse.
REQ-015 SHALL have ports perf_issue_cnt and perf_stall_cnt (both output, 32): performance counters.

Function
REQ-016 inst fields SHALL be: no_cal, load_acc, ld_sel[NUM_LOAD_CH], st_req, last; all remaining bits opaque; mac_inst = inst, passed through combinationally.
REQ-017 FSM SHALL have states IDLE, CAL and DRAIN; clear SHALL force IDLE and take priority over every transition.
REQ-018 issue SHALL be: IDLE & enable & inst_valid & ~no_cal & mac_ready & (ld_req_ready | ~ld_sel) on all channels & (~st_req | outstanding<MAX_STORE_OUT).
REQ-019 on issue, same cycle: inst_ready=1, mac_start=1 and ld_req_valid=ld_sel; the FSM SHALL then enter CAL and latch st_req and last.
REQ-020 in CAL, on mac_done: st_req_valid=1 if latched st_req, and outstanding SHALL be incremented; next state DRAIN if latched last, else IDLE.
REQ-021 outstanding SHALL be decremented on st_done; increment and decrement in the same cycle SHALL leave it unchanged.
REQ-022 in DRAIN, step_last SHALL pulse for one cycle and the FSM SHALL return to IDLE when outstanding==0, or when outstanding==1 with st_done in the same cycle.
REQ-023 a no_cal instruction in IDLE & enable SHALL be consumed without a state change; it SHALL need acc_ready if load_acc=1 (then acc_load=1 that cycle), and be consumed immediately if load_acc=0.
REQ-024 st_done while outstanding==0, or an increment at MAX_STORE_OUT, SHALL leave the counter unchanged (saturation); both are simulation assertion errors.
REQ-025 ld_req_valid, mac_start, st_req_valid, acc_load, inst_ready and step_last SHALL be 0 outside the conditions above.

Reset
REQ-026 on rstnn low: state IDLE, outstanding 0, latched fields 0, performance counters 0, all outputs 0.
REQ-027 clear SHALL NOT reset outstanding, so in-flight stores still retire.

Configuration
REQ-028 with DCA_STEP_ISSUER_PERF_EN defined: perf_issue_cnt SHALL increment per issue, and perf_stall_cnt per IDLE cycle with inst_valid & enable & no issue/consume; both SHALL wrap at 2^32 and be zeroed by clear.
REQ-029 without DCA_STEP_ISSUER_PERF_EN: both ports SHALL be tied to 0 and no counter flops synthesised.

Structure
REQ-030 package dca_step_issuer_pkg SHALL hold the state encoding, the inst field index functions of NUM_LOAD_CH, and the counter width $clog2(MAX_STORE_OUT+1).
REQ-031 the outstanding counter SHALL be sub-module dca_credit_counter (inc, dec, count, full, empty).

Verification
REQ-032 single step, ld_sel=2'b11, both ready, st_req=1, last=1 -> issue cycle 0; mac_done at 3 -> st_req_valid at 3; st_done at 6 -> step_last at 6; busy 0 at 7.
REQ-033 MAX_STORE_OUT=4, five st_req steps with no st_done -> fifth step held with inst_ready=0 until the first st_done, then issued the next cycle.
REQ-034 ld_req_ready=2'b01, ld_sel=2'b11 -> no issue; raise bit 1 -> issue that cycle; ld_sel=2'b01 with the same readiness -> immediate issue.
REQ-035 DRAIN with outstanding=1, st_done and increment-free cycle -> step_last the same cycle; DRAIN with outstanding=2 -> step_last only after the second st_done.
REQ-036 no_cal+load_acc with acc_ready=0 for 3 cycles -> inst_ready=0; acc_ready=1 -> acc_load=1 and inst_ready=1, state stays IDLE; with PERF_EN perf_stall_cnt=3.
REQ-037 clear in CAL with outstanding=2 -> IDLE next cycle, outstanding still 2; rstnn low mid-DRAIN -> all outputs 0 asynchronously.
